// File: rtl/regfile_dump_ctrl_pkg.sv
// Shared CPU debug definitions for the register-file dump controller:
// FSM state encoding, register count default and byte framing constants.
package regfile_dump_ctrl_pkg;

    localparam int NUM_REGS_DEFAULT = 32;
    localparam int BYTES_PER_REG    = 4;
    localparam int BYTE_W           = 8;
    localparam int REG_ADDR_W       = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } dump_state_e;

    function automatic logic [REG_ADDR_W-1:0] next_index(input logic [REG_ADDR_W-1:0] idx);
        return idx + 5'd1;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// Register-file read port and UART byte handshake between the dump
// controller (master) and its environment (slave).
interface regfile_dump_ctrl_if
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [REG_ADDR_W-1:0] o_rf_addr;
    logic [DATA_WIDTH-1:0] i_rf_data;
    logic [BYTE_W-1:0]     o_tx_data;
    logic                  o_tx_valid;
    logic                  i_tx_ready;

    modport master (
        output o_rf_addr,
        output o_tx_data,
        output o_tx_valid,
        input  i_rf_data,
        input  i_tx_ready
    );

    modport slave (
        input  o_rf_addr,
        input  o_tx_data,
        input  o_tx_valid,
        output i_rf_data,
        output i_tx_ready
    );
endinterface

// File: rtl/regfile_dump_ctrl_word_serializer.sv
// Splits one register word into bytes, least significant first, over a
// valid/ready handshake; pulses word_done on the final byte transfer.
module regfile_dump_ctrl_word_serializer
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  tx_ready,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_valid,
    output logic                  word_done
);
    localparam int CNT_W = $clog2(BYTES_PER_REG);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_REG - 1);

    logic [DATA_WIDTH-1:0] shift_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BYTE_W-1:0]     tx_data_r;
    logic                  tx_valid_r;
    logic                  xfer_s;

    assign xfer_s    = tx_valid_r && tx_ready;
    assign word_done = xfer_s && (cnt_r == LAST_BYTE);
    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;

    // tx_data is a separate register so it holds the last byte once the
    // shift register has drained to zero.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            shift_r    <= '0;
            cnt_r      <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else if (load) begin
            shift_r    <= word;
            cnt_r      <= '0;
            tx_data_r  <= word[BYTE_W-1:0];
            tx_valid_r <= 1'b1;
        end else if (xfer_s) begin
            shift_r <= shift_r >> BYTE_W;
            cnt_r   <= cnt_r + 1'b1;
            if (cnt_r == LAST_BYTE) begin
                tx_valid_r <= 1'b0;
            end else begin
                tx_data_r <= shift_r[2*BYTE_W-1:BYTE_W];
            end
        end else begin
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// Dumps registers 0..NUM_REGS-1 of a halted CPU to a UART byte stream,
// borrowing register-file read port 1 while the dump runs.
module regfile_dump_ctrl
    import regfile_dump_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = NUM_REGS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_halted,
    input  logic [REG_ADDR_W-1:0] i_cpu_addr,
    output logic                  o_busy,
    output logic                  o_done,
    regfile_dump_ctrl_if.master   bus
);
    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    dump_state_e           state_r;
    logic [REG_ADDR_W-1:0] index_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  load_s;
    logic                  word_done_s;

    assign load_s = (state_r == ST_LOAD);
    assign o_busy = busy_r;
    assign o_done = done_r;

    // Read port 1 belongs to the pipeline only while idle.
    always_comb begin
        bus.o_rf_addr = index_r;
        if (state_r == ST_IDLE) begin
            bus.o_rf_addr = i_cpu_addr;
        end else begin
            bus.o_rf_addr = index_r;
        end
    end

    regfile_dump_ctrl_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .i_rst     (i_rst),
        .load      (load_s),
        .word      (bus.i_rf_data),
        .tx_ready  (bus.i_tx_ready),
        .tx_data   (bus.o_tx_data),
        .tx_valid  (bus.o_tx_valid),
        .word_done (word_done_s)
    );

    // Dump sequencer; busy/done are registered alongside the state so they
    // change on exactly the edges that enter or leave IDLE/DONE.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            index_r <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_start && i_halted) begin
                        state_r <= ST_LOAD;
                        index_r <= 5'd0;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_SEND;
                end
                ST_SEND: begin
                    if (word_done_s) begin
                        state_r <= ST_NEXT;
                    end else begin
                        state_r <= ST_SEND;
                    end
                end
                ST_NEXT: begin
                    if (index_r == LAST_IDX) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        index_r <= next_index(index_r);
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed self-checking bench for regfile_dump_ctrl: full dumps with fixed
// and random ready, start filtering, halt drop and mid-dump reset.
module tb_regfile_dump_ctrl;
    import regfile_dump_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_halted = 1'b0;
    logic [4:0]  i_cpu_addr = 5'd0;
    logic        o_busy;
    logic        o_done;

    logic [31:0] rf [32];
    logic [7:0]  bytes_q [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    regfile_dump_ctrl_if #(.DATA_WIDTH(32)) bus ();

    regfile_dump_ctrl #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_halted   (i_halted),
        .i_cpu_addr (i_cpu_addr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .bus        (bus)
    );

    assign bus.i_rf_data = rf[bus.o_rf_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte capture, done counting and hold-while-stalled checks at negedge.
    always @(negedge clk) begin
        if (prev_hold) begin
            check("hold_valid", {31'd0, bus.o_tx_valid}, 32'd1);
            check("hold_data", {24'd0, bus.o_tx_data}, {24'd0, prev_data});
        end
        prev_hold = bus.o_tx_valid && !bus.i_tx_ready && !i_rst;
        prev_data = bus.o_tx_data;
        if (bus.o_tx_valid && bus.i_tx_ready) bytes_q.push_back(bus.o_tx_data);
        if (o_done) done_cnt++;
    end

    task automatic check_stream(input string tag);
        int mism;
        logic [31:0] w;
        mism = 0;
        check({tag, "_len"}, bytes_q.size(), 32'd128);
        for (int k = 0; k < bytes_q.size() && k < 128; k++) begin
            w = rf[k / 4] >> (8 * (k % 4));
            if (bytes_q[k] !== w[7:0]) mism++;
        end
        check({tag, "_bytes"}, mism, 32'd0);
    endtask

    initial begin
        int cyc, first_v, done_cyc, base_done, found;
        for (int r = 0; r < 32; r++) rf[r] = 32'hA5C30000 | 32'(r * 257);
        rf[0]  = 32'h00000000;
        rf[1]  = 32'h11223344;
        rf[31] = 32'hDEADBEEF;
        bus.i_tx_ready = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
        check("rst_data", {24'd0, bus.o_tx_data}, 32'd0);
        i_rst = 1'b0;

        // Start without halt is ignored; address follows the pipeline
        i_halted = 1'b0; i_start = 1'b1; i_cpu_addr = 5'd5;
        tick(); tick(); tick();
        check("nohalt_busy", {31'd0, o_busy}, 32'd0);
        check("idle_addr5", {27'd0, bus.o_rf_addr}, 32'd5);
        i_cpu_addr = 5'd17; #1;
        check("idle_addr17", {27'd0, bus.o_rf_addr}, 32'd17);
        i_start = 1'b0;

        // Reset and start on the same edge
        i_rst = 1'b1; i_start = 1'b1; i_halted = 1'b1;
        tick();
        i_rst = 1'b0; i_start = 1'b0;
        tick();
        check("rst_start_busy", {31'd0, o_busy}, 32'd0);

        // Full dump, ready tied high, with latency checks
        bytes_q.delete();
        base_done = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        cyc = 1; first_v = 0; done_cyc = 0;
        for (int i = 0; i < 400 && done_cyc == 0; i++) begin
            tick();
            cyc++;
            if (bus.o_tx_valid && first_v == 0) first_v = cyc;
            if (o_done) done_cyc = cyc;
        end
        check("first_valid_cyc", first_v, 32'd2);
        check("done_cyc", done_cyc, 32'd193);
        tick();
        check("after_done_busy", {31'd0, o_busy}, 32'd0);
        check("done_pulses", done_cnt - base_done, 32'd1);
        check_stream("dump1");
        check("b0", {24'd0, bytes_q[0]}, 32'h00);
        check("b3", {24'd0, bytes_q[3]}, 32'h00);
        check("b4", {24'd0, bytes_q[4]}, 32'h44);
        check("b5", {24'd0, bytes_q[5]}, 32'h33);
        check("b6", {24'd0, bytes_q[6]}, 32'h22);
        check("b7", {24'd0, bytes_q[7]}, 32'h11);
        check("b124", {24'd0, bytes_q[124]}, 32'hEF);
        check("b125", {24'd0, bytes_q[125]}, 32'hBE);
        check("b126", {24'd0, bytes_q[126]}, 32'hAD);
        check("b127", {24'd0, bytes_q[127]}, 32'hDE);

        // Random ready, roughly 30% high
        bytes_q.delete();
        base_done = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        found = 0;
        for (int i = 0; i < 5000 && found == 0; i++) begin
            bus.i_tx_ready = ($urandom_range(0, 9) < 3);
            tick();
            if (o_done) found = 1;
        end
        bus.i_tx_ready = 1'b1;
        check("rand_done_seen", found, 32'd1);
        tick();
        check_stream("rand");
        check("rand_done_pulses", done_cnt - base_done, 32'd1);

        // Start pulses during the dump and halt dropped at byte 50
        bytes_q.delete();
        base_done = done_cnt;
        i_start = 1'b1;
        tick();
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            i_start = ~i_start;
            if (bytes_q.size() >= 50) i_halted = 1'b0;
            tick();
            if (o_done) begin
                found = 1;
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        check("spam_done_seen", found, 32'd1);
        tick(); tick(); tick();
        check_stream("spam");
        check("spam_done_pulses", done_cnt - base_done, 32'd1);
        check("spam_idle", {31'd0, o_busy}, 32'd0);

        // Reset during SEND of register 10, then a clean dump from x0
        i_halted = 1'b1;
        base_done = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            tick();
            if (bus.o_rf_addr == 5'd10 && bus.o_tx_valid) found = 1;
        end
        check("reg10_reached", found, 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_valid", {31'd0, bus.o_tx_valid}, 32'd0);
        check("midrst_busy", {31'd0, o_busy}, 32'd0);
        tick(); tick();
        check("midrst_no_done", done_cnt - base_done, 32'd0);
        bytes_q.delete();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("restart_addr0", {27'd0, bus.o_rf_addr}, 32'd0);
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick();
            if (o_done) found = 1;
        end
        check("restart_done_seen", found, 32'd1);
        tick();
        check_stream("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set register word width in bits; fixed at 32 for this release.
REQ-002 Parameter NUM_REGS, default 32, SHALL set the number of registers dumped (indices 0..NUM_REGS-1).
REQ-003 One clock; reset is synchronous and active-high; ports named clk and i_rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 i_rst  input  1  synchronous active-high reset.
REQ-006 i_start  input  1  dump request, sampled only in IDLE.
REQ-007 i_halted  input  1  CPU pipeline halted; gates acceptance of i_start.
REQ-008 i_cpu_addr  input  5  pipeline read-port-1 register address.
REQ-009 i_rf_data  input  DATA_WIDTH  register file read-port-1 data (combinational read).
REQ-010 o_rf_addr  output  5  address driven to register file read port 1.
REQ-011 o_tx_data  output  8  byte to UART transmitter.
REQ-012 o_tx_valid  output  1  byte valid.
REQ-013 i_tx_ready  input  1  transmitter accepts byte this cycle.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_done  output  1  one-cycle completion pulse.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, SEND, NEXT, DONE.
REQ-017 In IDLE o_rf_addr SHALL equal i_cpu_addr combinationally; in every other state it SHALL equal the 5-bit dump index.
REQ-018 IDLE -> LOAD when i_start && i_halted at a rising edge; dump index cleared to 0; i_start with i_halted low SHALL be ignored.
REQ-019 LOAD SHALL capture i_rf_data into a 32-bit shift register, clear byte counter, go to SEND (one cycle).
REQ-020 SEND SHALL assert o_tx_valid with o_tx_data = shift register bits [7:0] (little-endian, byte 0 first).
REQ-021 o_tx_valid and o_tx_data SHALL remain stable until a cycle with i_tx_ready high; a byte transfers on valid && ready.
REQ-022 On transfer the shift register SHALL shift right 8 and the byte counter increment; after the 4th transfer go to NEXT.
REQ-023 NEXT: if index == NUM_REGS-1 go to DONE, else increment index and go to LOAD.
REQ-024 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-025 o_tx_valid SHALL be low outside SEND; o_tx_data holds its last value when not valid.
REQ-026 i_start while o_busy is high SHALL be ignored; no queuing.
REQ-027 i_halted deasserting mid-dump SHALL NOT abort; the dump completes.
REQ-028 Register 0 data is whatever the register file returns (zero); no special-casing.
REQ-029 With i_tx_ready tied high: first o_tx_valid 2 cycles after the start edge, 6 cycles per register, o_done 193 cycles after the start edge for NUM_REGS=32.

Reset
REQ-030 i_rst SHALL force IDLE, index 0, byte counter 0, shift register 0, o_tx_data 0, o_tx_valid 0, o_busy 0, o_done 0.
REQ-031 Reset mid-dump SHALL take effect at the next edge; o_tx_valid drops without completing the handshake; no o_done.
REQ-032 i_rst SHALL take priority over i_start on the same edge.

Structure
REQ-033 State encoding, NUM_REGS default, BYTES_PER_REG (4) and byte width SHALL live in a shared cpu debug package.
REQ-034 Byte serialization (shift register plus byte counter plus valid/ready handling) MAY be one sub-module, word_serializer; FSM and address mux stay in regfile_dump_ctrl.

Verification
REQ-035 Registers preloaded x1=0x11223344, x31=0xDEADBEEF, ready tied high, start with halted=1 -> 128 bytes; bytes 4..7 = 44 33 22 11; bytes 124..127 = EF BE AD DE; bytes 0..3 = 00; o_done at cycle 193.
REQ-036 i_start with i_halted=0 -> o_busy stays 0; o_rf_addr tracks i_cpu_addr (e.g. 5 -> 5).
REQ-037 Random i_tx_ready (30% high) -> o_tx_data never changes while valid && !ready; byte stream identical to REQ-035.
REQ-038 i_start pulses during dump and i_halted dropped at byte 50 -> single dump of 128 bytes, one o_done pulse.
REQ-039 i_rst asserted during SEND of register 10 -> next cycle o_tx_valid=0, o_busy=0, no o_done; new start dumps from x0.
REQ-040 i_rst and i_start high on the same edge -> FSM remains IDLE.
